// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Round-robin arbiter sharing one pipelined 16x16 unsigned multiplier
//   between NUM_REQ requesters. Each requester has at most one operation
//   outstanding; its product is returned through a one-entry result register.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset (shared with multiplier)
//   req_valid/ready per-requester operand handshake (req_ready is a one-hot grant)
//   req_a, req_b    packed operands, requester i at [16i+15:16i]
//   resp_valid/ready per-requester result handshake
//   resp_prod       packed products, requester i at [32i+31:32i]
//   mult_a, mult_b  operands driven to the external multiplier
//   mult_prod       product from the external multiplier (MULT_LAT edges later)
//   busy            any requester has an operation pending
module mult_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int MULT_LAT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [32*NUM_REQ-1:0] resp_prod,
    output logic [15:0]           mult_a,
    output logic [15:0]           mult_b,
    input  logic [31:0]           mult_prod,
    output logic                  busy
);

    localparam int          TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NR    = NUM_REQ;

    logic [NUM_REQ-1:0]             r_pending;
    logic [TAG_W-1:0]               r_last_grant;
    logic [MULT_LAT-1:0]            r_tag_v;
    logic [TAG_W-1:0]               r_tag [MULT_LAT];
    logic [NUM_REQ-1:0]             r_resp_valid;
    logic [NUM_REQ-1:0][31:0]       r_resp_prod;

    logic [NUM_REQ-1:0][15:0]       w_req_a;
    logic [NUM_REQ-1:0][15:0]       w_req_b;
    logic [NUM_REQ-1:0]             w_elig;
    logic [NUM_REQ-1:0]             w_grant;
    logic [TAG_W-1:0]               w_grant_idx;
    logic                           w_issue;

    assign w_req_a = req_a;
    assign w_req_b = req_b;
    assign w_elig  = req_valid & ~r_pending;

    // Requester index at distance 'off' past 'base', wrapping at NUM_REQ.
    function automatic logic [TAG_W-1:0] rr_idx(input logic [TAG_W-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = (32'(base) + off) % NR;
        return TAG_W'(sum);
    endfunction

    // Search starts one past the last grant; offset NR lands back on the
    // last granted requester, so it has lowest priority.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_issue     = 1'b0;
        for (int unsigned k = 1; k <= NR; k++) begin
            if (!w_issue && w_elig[rr_idx(r_last_grant, k)]) begin
                w_issue     = 1'b1;
                w_grant_idx = rr_idx(r_last_grant, k);
            end
        end
        if (rst) begin
            w_issue     = 1'b0;
            w_grant_idx = '0;
        end
        if (w_issue) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign req_ready  = w_grant;
    assign mult_a     = w_issue ? w_req_a[w_grant_idx] : '0;
    assign mult_b     = w_issue ? w_req_b[w_grant_idx] : '0;
    assign resp_valid = r_resp_valid;
    assign resp_prod  = r_resp_prod;
    assign busy       = |r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending    <= '0;
            r_last_grant <= TAG_W'(NUM_REQ - 1);
            r_tag_v      <= '0;
            for (int unsigned s = 0; s < MULT_LAT; s++) begin
                r_tag[s] <= '0;
            end
            r_resp_valid <= '0;
            r_resp_prod  <= '0;
        end else begin
            if (w_issue) begin
                r_last_grant <= w_grant_idx;
            end

            // Tag pipeline mirrors the multiplier so the last stage names the
            // owner of the product currently on mult_prod.
            r_tag_v[0] <= w_issue;
            r_tag[0]   <= w_grant_idx;
            for (int unsigned s = 1; s < MULT_LAT; s++) begin
                r_tag_v[s] <= r_tag_v[s-1];
                r_tag[s]   <= r_tag[s-1];
            end

            // A grant and a response handshake never hit the same requester
            // in one cycle, since pending blocks the grant until consumption.
            r_pending <= (r_pending | w_grant) & ~(r_resp_valid & resp_ready);

            for (int unsigned i = 0; i < NR; i++) begin
                if (r_resp_valid[i] && resp_ready[i]) begin
                    r_resp_valid[i] <= 1'b0;
                end
            end

            if (r_tag_v[MULT_LAT-1]) begin
                r_resp_valid[r_tag[MULT_LAT-1]] <= 1'b1;
                r_resp_prod[r_tag[MULT_LAT-1]]  <= mult_prod;
            end
        end
    end

endmodule
